// File: rtl/tsense_pkg.sv
// Shared definitions for the temperature-sensor readout path and its register map.
package tsense_pkg;

    localparam int unsigned TSENSE_DIV_MIN = 3;
    localparam int unsigned TSENSE_DATA_W  = 16;
    localparam int unsigned TSENSE_DIV     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } tsense_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, cleared by reset.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tsense_sr_reader.sv
// Serial readout master: drives the sensor shift clock, captures sr_in MSB-first
// and presents the frame on a valid/ack handshake.
module tsense_sr_reader
    import tsense_pkg::*;
#(
    parameter int unsigned DATA_W = TSENSE_DATA_W,
    parameter int unsigned DIV    = TSENSE_DIV
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              sr_in,
    output logic              shift_clk_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    input  logic              data_ack_i,
    output logic              overrun_o
);

    localparam int unsigned PH_W = $clog2(DIV);
    localparam int unsigned BC_W = $clog2(DATA_W + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    if (DIV < TSENSE_DIV_MIN) begin : g_bad_div
        $error("tsense_sr_reader: DIV below TSENSE_DIV_MIN");
    end

    tsense_state_e     state, state_nx;
    logic [PH_W-1:0]   phase, phase_nx;
    logic [BC_W-1:0]   bit_cnt, bit_nx;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic [DATA_W-1:0] data_nx;
    logic              valid_nx, overrun_nx, sclk_nx, busy_nx;
    logic              capture, clr_ovr, phase_last;
    logic              sr_sync;

    sync_2ff #(.W(1)) u_sync_sr (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (sr_in),
        .q   (sr_sync)
    );

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        bit_nx     = bit_cnt;
        shreg_nx   = shreg;
        capture    = 1'b0;
        clr_ovr    = 1'b0;
        phase_last = (phase == PH_LAST);

        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nx = ST_LOW;
                    phase_nx = '0;
                    bit_nx   = '0;
                    clr_ovr  = 1'b1;
                end
            end
            ST_LOW: begin
                if (phase_last) begin
                    phase_nx = '0;
                    shreg_nx = {shreg[DATA_W-2:0], sr_sync};
                    state_nx = ST_HIGH;
                end else begin
                    phase_nx = PH_W'(phase + 1'b1);
                end
            end
            ST_HIGH: begin
                if (phase_last) begin
                    phase_nx = '0;
                    bit_nx   = BC_W'(bit_cnt + 1'b1);
                    if (bit_cnt == BC_LAST) begin
                        state_nx = ST_DONE;
                        capture  = 1'b1;
                    end else begin
                        state_nx = ST_LOW;
                    end
                end else begin
                    phase_nx = PH_W'(phase + 1'b1);
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase

        // A completing frame always wins over a same-cycle acknowledge
        data_nx    = capture ? shreg : data_o;
        valid_nx   = data_valid_o;
        overrun_nx = overrun_o;
        if (capture) begin
            valid_nx = 1'b1;
        end else if (data_ack_i && data_valid_o) begin
            valid_nx = 1'b0;
        end
        if (clr_ovr) begin
            overrun_nx = 1'b0;
        end else if (capture && data_valid_o && !data_ack_i) begin
            overrun_nx = 1'b1;
        end

        sclk_nx = (state_nx == ST_HIGH);
        busy_nx = (state_nx == ST_LOW) || (state_nx == ST_HIGH);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= ST_IDLE;
            phase        <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
            shift_clk_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state        <= state_nx;
            phase        <= phase_nx;
            bit_cnt      <= bit_nx;
            shreg        <= shreg_nx;
            data_o       <= data_nx;
            data_valid_o <= valid_nx;
            overrun_o    <= overrun_nx;
            shift_clk_o  <= sclk_nx;
            busy_o       <= busy_nx;
        end
    end

endmodule

// File: tb/tb_tsense_sr_reader.sv
// Randomized and directed bench for tsense_sr_reader against a cycle-count reference model.
module tb_tsense_sr_reader;

    localparam int unsigned DATA_W = 16;
    localparam int          DIV    = 4;
    localparam int          FRAME  = 2 * DIV * DATA_W;

    logic              wb_clk_i;
    logic              wb_rst_i;
    logic              start_i;
    logic              sr_in;
    logic              shift_clk_o;
    logic              busy_o;
    logic [DATA_W-1:0] data_o;
    logic              data_valid_o;
    logic              data_ack_i;
    logic              overrun_o;

    tsense_sr_reader #(.DATA_W(DATA_W), .DIV(DIV)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .start_i      (start_i),
        .sr_in        (sr_in),
        .shift_clk_o  (shift_clk_o),
        .busy_o       (busy_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ack_i   (data_ack_i),
        .overrun_o    (overrun_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sensor: first bit presented before the first rise, next bit on each rise
    logic [DATA_W-1:0] sens_word = '0;
    int                sens_idx  = 0;
    int                rises     = 0;

    task automatic sensor_load(input logic [DATA_W-1:0] w);
        sens_word = w;
        sens_idx  = DATA_W - 1;
        sr_in     = w[DATA_W-1];
    endtask

    always @(posedge shift_clk_o) begin
        rises++;
        if (sens_idx > 0) sens_idx--;
        sr_in = sens_word[sens_idx];
    end

    // Reference: a frame completes FRAME cycles after its accepted start
    logic              m_active, m_done, m_valid, m_over;
    logic [DATA_W-1:0] m_data, m_word;
    int                m_cnt;

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            m_active = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_over = 1'b0;
            m_data   = '0;   m_word = '0;   m_cnt   = 0;
        end else if (m_active && m_cnt == FRAME) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            if (m_valid && !data_ack_i) m_over = 1'b1;
            m_valid  = 1'b1;
            m_data   = m_word;
        end else begin
            if (data_ack_i) m_valid = 1'b0;
            if (m_active) begin
                m_cnt++;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (start_i) begin
                m_active = 1'b1;
                m_cnt    = 1;
                m_over   = 1'b0;
                m_word   = sens_word;
            end
        end
    end

    logic chk_en = 1'b0;

    always @(negedge wb_clk_i) begin
        if (chk_en) begin
            check("busy",  32'(busy_o),       32'(m_active));
            check("sclk",  32'(shift_clk_o),  32'(m_active && (((m_cnt - 1) / DIV) % 2 == 1)));
            check("valid", 32'(data_valid_o), 32'(m_valid));
            check("ovr",   32'(overrun_o),    32'(m_over));
            check("data",  32'(data_o),       32'(m_data));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    // Runs one frame; ack_at / start_at are cycle offsets from the start edge (-1 = none)
    task automatic frame(input logic [DATA_W-1:0] w, input int ack_at, input int start_at);
        int n;
        sensor_load(w);
        rises   = 0;
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        n = 1;
        check("busy_e1", 32'(busy_o), 32'd1);
        while (n < FRAME + 2) begin
            data_ack_i = (n == ack_at);
            start_i    = (n == start_at);
            @(negedge wb_clk_i);
            n++;
            if (n == FRAME) check("busy_e128", 32'(busy_o), 32'd1);
            if (n == FRAME + 1) begin
                check("data_e129",  32'(data_o),       32'(w));
                check("valid_e129", 32'(data_valid_o), 32'd1);
                check("busy_e129",  32'(busy_o),       32'd0);
            end
        end
        data_ack_i = 1'b0;
        start_i    = 1'b0;
        check("rises", 32'(rises), 32'(DATA_W));
    endtask

    task automatic pulse_ack();
        data_ack_i = 1'b1;
        @(negedge wb_clk_i);
        data_ack_i = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] w;
        int                r, ack_at, st_at;
        wb_rst_i   = 1'b1;
        start_i    = 1'b0;
        data_ack_i = 1'b0;
        sr_in      = 1'b0;
        cycles(2);
        check("rst_busy",  32'(busy_o),       32'd0);
        check("rst_sclk",  32'(shift_clk_o),  32'd0);
        check("rst_valid", 32'(data_valid_o), 32'd0);
        check("rst_ovr",   32'(overrun_o),    32'd0);
        check("rst_data",  32'(data_o),       32'd0);
        #2 wb_rst_i = 1'b0;
        cycles(2);
        chk_en = 1'b1;

        // Basic frame, then hold off the ack for a while before pulsing it
        frame(16'hA5C3, -1, -1);
        cycles(5);
        check("hold_valid", 32'(data_valid_o), 32'd1);
        pulse_ack();
        check("ack_clear", 32'(data_valid_o), 32'd0);
        check("ack_data",  32'(data_o),       32'h0000A5C3);
        frame(16'h0001, -1, -1);
        pulse_ack();

        // Overrun and its clear on the next start
        frame(16'h1234, -1, -1);
        frame(16'hFFFF, -1, -1);
        check("ovr_set",  32'(overrun_o), 32'd1);
        check("ovr_data", 32'(data_o),    32'h0000FFFF);
        sensor_load(16'h0F0F);
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        check("ovr_clr", 32'(overrun_o), 32'd0);
        cycles(FRAME + 1);
        check("ovr_frame_data", 32'(data_o), 32'h00000F0F);

        // Ack on the completing edge: new frame kept, no overrun
        frame(16'hBEEF, FRAME, -1);
        check("coinc_valid", 32'(data_valid_o), 32'd1);
        check("coinc_ovr",   32'(overrun_o),    32'd0);
        pulse_ack();

        // Start mid-frame is ignored
        frame(16'h3C96, -1, 40);
        cycles(3);
        check("no_second_busy", 32'(busy_o), 32'd0);
        pulse_ack();

        // Asynchronous reset mid-frame, then a clean frame
        sensor_load(16'h7777);
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        cycles(59);
        #2 wb_rst_i = 1'b1;
        #1;
        check("mid_rst_busy",  32'(busy_o),       32'd0);
        check("mid_rst_sclk",  32'(shift_clk_o),  32'd0);
        check("mid_rst_valid", 32'(data_valid_o), 32'd0);
        check("mid_rst_ovr",   32'(overrun_o),    32'd0);
        check("mid_rst_data",  32'(data_o),       32'd0);
        cycles(3);
        #2 wb_rst_i = 1'b0;
        cycles(2);
        frame(16'h5A5A, -1, -1);

        // Randomized back-to-back frames with assorted ack/start timing
        for (int i = 0; i < 10; i++) begin
            w  = DATA_W'($urandom);
            r  = int'($urandom_range(0, 3));
            ack_at = (r == 1) ? FRAME : (r == 2) ? FRAME + 1 : (r == 3) ? int'($urandom_range(2, 120)) : -1;
            st_at  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 120)) : -1;
            frame(w, ack_at, st_at);
            if ($urandom_range(0, 1) == 1) begin
                cycles(int'($urandom_range(0, 3)));
                pulse_ack();
            end
        end

        cycles(3);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tsense_sr_reader.md
# tsense_sr_reader

Serial readout master for the temperature-sensor digital core. It generates the shift clock and captures the core's serial result stream (`sr_out`) MSB-first into a parallel word. It presents that word on a valid/ack handshake to the Wishbone register file. It sits beside the sensor digital core in the user project area and runs entirely on the Wishbone clock.

## Interface
Parameters:
- `DATA_W`, default 16: number of bits per readout frame.
- `DIV`, default 4: half-period of `shift_clk_o`, in `wb_clk_i` cycles; legal range ≥ 3.

Ports:
- `wb_clk_i`, input, 1: the single clock. All logic is on its rising edge.
- `wb_rst_i`, input, 1: reset. Asynchronous, active-high.
- `start_i`, input, 1: single-cycle request to read one frame.
- `sr_in`, input, 1: serial data from the sensor core's `sr_out`. Asynchronous to `wb_clk_i`.
- `shift_clk_o`, output, 1: shift clock to the sensor core.
- `busy_o`, output, 1: frame in progress.
- `data_o`, output, DATA_W: last captured frame.
- `data_valid_o`, output, 1: `data_o` holds an unacknowledged frame.
- `data_ack_i`, input, 1: consumer acknowledge.
- `overrun_o`, output, 1: sticky flag; a frame completed while the previous one was unacknowledged.

## Operation
- `sr_in` passes through a 2-FF synchronizer before any use.
- The FSM has four states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - `shift_clk_o` = 0, `busy_o` = 0.
  - `start_i` = 1 → LOW. This clears the phase counter and the bit counter, and clears `overrun_o`.
- LOW:
  - `shift_clk_o` = 0 for DIV cycles.
  - On the last LOW cycle, the synchronized `sr_in` is shifted into the LSB of the shift register; earlier bits move toward the MSB.
  - Then → HIGH.
- HIGH:
  - `shift_clk_o` = 1 for DIV cycles.
  - On the last HIGH cycle, the bit counter increments.
  - If the bit counter reaches DATA_W → DONE; otherwise → LOW.
- DONE, one cycle:
  - `data_o` ← shift register, `data_valid_o` ← 1.
  - If `data_valid_o` was already 1 and no `data_ack_i` arrives in this cycle, `overrun_o` ← 1. The new data overwrites the old.
  - Then → IDLE.
- The sensor core is required to update `sr_out` on the rising edge of shift clock, with the first bit present before the first rise. Sampling late in LOW leaves DIV−2 cycles of settling after synchronization.
- Handshake:
  - `data_valid_o` clears on the cycle after `data_ack_i` = 1 while valid.
  - `data_ack_i` with valid = 0 is ignored.
  - When ack and DONE coincide, the new frame wins: valid stays 1 and no overrun is flagged.
- `start_i` while `busy_o` = 1 is ignored and does not queue.
- Widths:
  - Phase counter is $clog2(DIV) bits.
  - Bit counter is $clog2(DATA_W+1) bits.
  - No wrap occurs within a frame.

## Timing
- Reset values:
  - `shift_clk_o` = 0, `busy_o` = 0, `data_valid_o` = 0, `overrun_o` = 0.
  - `data_o` = 0, shift register = 0, synchronizer = 0, state = IDLE.
- Reset asserted mid-frame: everything returns to reset values immediately and `shift_clk_o` drops to 0. No partial frame is delivered.
- With `start_i` sampled at edge E:
  - `busy_o` = 1 from E+1.
  - The first `shift_clk_o` rise is at E+1+DIV.
  - Each bit takes 2·DIV cycles.
  - `data_valid_o` rises and `busy_o` falls at E + 2·DIV·DATA_W + 1. With the defaults this is E+129.
- `shift_clk_o` is a registered output with glitch-free 50% duty.
- The earliest back-to-back restart is `start_i` in the first IDLE cycle after DONE.

## Structure
- Shared package `tsense_pkg`:
  - FSM state enum.
  - `TSENSE_DIV_MIN` = 3.
  - Default `DATA_W`/`DIV` constants, also used by the Wishbone register map.
- Sub-module `sync_2ff` for `sr_in`; it is reused for other asynchronous inputs in the wrapper.
- An elaboration check fails the build if `DIV` < `TSENSE_DIV_MIN`.

## Test plan
- Basic frame: behavioural sensor model shifts 0xA5C3 on `shift_clk_o` rises, `start_i` pulse → `data_o` = 0xA5C3 and `data_valid_o` = 1 at E+129. Exactly 16 `shift_clk_o` rises, each high for 4 cycles.
- Handshake: hold ack low, then pulse `data_ack_i` → valid clears next cycle and `data_o` is unchanged. A second frame 0x0001 → `data_o` = 0x0001.
- Overrun: two frames 0x1234 then 0xFFFF with no ack → `data_o` = 0xFFFF and `overrun_o` = 1. The next `start_i` clears `overrun_o`.
- Ack coincident with DONE: valid stays 1 and `overrun_o` stays 0.
- Ignored start: pulse `start_i` at E+40 during a frame → frame timing is unchanged and `busy_o` falls at E+129 with no second frame.
- Reset mid-frame: assert `wb_rst_i` at E+60 → all outputs go to 0 asynchronously. After release, a new frame 0x5A5A is captured correctly.
